pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It splits a WIDTH-bit operation into WIDTH/BLOCK lookahead blocks, one block per pipeline stage, with a registered carry between stages. It adds carry-in, subtract mode, signed-overflow detection and backpressure. It sits in datapaths that need one add/sub per clock at widths where a single-cycle lookahead chain misses timing.

---
 rtl/pipelined_cla_adder_if.sv | 26 ++
 rtl/pipelined_cla_adder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Stream interface for the pipelined CLA adder: operand beat in, {carry, sum} beat out.
// The master side is the producer/consumer; the slave side is the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add1;
    logic [WIDTH-1:0] i_add2;
    logic             i_carry;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic             o_overflow;

    modport master (
        output i_valid, i_add1, i_add2, i_carry, i_sub, i_ready,
        input  o_ready, o_valid, o_result, o_overflow
    );

    modport slave (
        input  i_valid, i_add1, i_add2, i_carry, i_sub, i_ready,
        output o_ready, o_valid, o_result, o_overflow
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead slice per stage,
// registered inter-stage carry, skewed operands and deskewed sums, global stall on backpressure.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input logic                  i_clk,
    input logic                  i_rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int STAGES = WIDTH / BLOCK;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH < 1 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be >= 1 and a multiple of BLOCK");
    end

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cry_q;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;

    // Per-stage inputs: stage 0 sees the bus, stage k sees the registers of stage k-1.
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_nxt;
    logic              ovf_nxt;

    assign adv            = !vld_q[STAGES-1] || bus.i_ready;
    assign bus.o_ready    = adv;
    assign bus.o_valid    = vld_q[STAGES-1];
    assign bus.o_result   = {cry_q[STAGES-1], s_q[STAGES-1]};
    assign bus.o_overflow = ovf_q;

    assign a_in[0] = bus.i_add1;
    assign b_in[0] = bus.i_sub ? ~bus.i_add2 : bus.i_add2;
    assign s_in[0] = '0;
    assign c_in[0] = bus.i_carry ^ bus.i_sub;
    assign v_in[0] = bus.i_valid;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign s_in[k] = s_q[k-1];
        assign c_in[k] = cry_q[k-1];
        assign v_in[k] = vld_q[k-1];
    end

    // Operand skew registers exist only when there is a later stage to feed.
    if (STAGES > 1) begin : g_skew
        logic [WIDTH-1:0] a_q [STAGES-1];
        logic [WIDTH-1:0] b_q [STAGES-1];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end
            end else if (adv) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                end
            end
        end

        for (genvar k = 1; k < STAGES; k++) begin : g_fwd
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
        end
    end

    always_comb begin
        logic c;
        logic g;
        logic p;
        logic ab;
        logic bb;
        c       = 1'b0;
        g       = 1'b0;
        p       = 1'b0;
        ab      = 1'b0;
        bb      = 1'b0;
        ovf_nxt = 1'b0;
        c_nxt   = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k] = s_in[k];
            // NOTE: blocking '=' here makes c a combinational chain through the unrolled block.
            c = c_in[k];
            for (int i = 0; i < BLOCK; i++) begin
                ab = a_in[k][k*BLOCK+i];
                bb = b_in[k][k*BLOCK+i];
                g  = ab & bb;
                p  = ab | bb;
                s_nxt[k][k*BLOCK+i] = ab ^ bb ^ c;
                c  = g | (p & c);
            end
            c_nxt[k] = c;
        end
        ovf_nxt = (a_in[STAGES-1][MSB] == b_in[STAGES-1][MSB]) &&
                  (s_nxt[STAGES-1][MSB] != a_in[STAGES-1][MSB]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the result arrays are cleared on reset because o_result must read 0 afterwards.
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) s_q[k] <= '0;
        end else if (adv) begin
            vld_q <= v_in;
            cry_q <= c_nxt;
            ovf_q <= ovf_nxt;
            for (int k = 0; k < STAGES; k++) s_q[k] <= s_nxt[k];
        end
    end
endmodule
